// File: rtl/stream_demultiplexer.sv
// Registered 1-to-DEPTH stream demultiplexer with a one-entry buffer per channel.
// Optional saturating drop counter enabled by defining DEMUX_DROP_CNT_EN.
module stream_demultiplexer #(
    parameter  int WIDTH      = 1,
    parameter  int DEPTH      = 2,
    localparam int ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WIDTH-1:0]      d,
    input  logic                  d_valid,
    output logic                  d_ready,
    output logic [WIDTH-1:0]      q [DEPTH-1:0],
    output logic [DEPTH-1:0]      q_valid,
    input  logic [DEPTH-1:0]      q_ready,
`ifdef DEMUX_DROP_CNT_EN
    output logic                  drop,
    output logic [7:0]            drop_cnt
`else
    output logic                  drop
`endif
);

    // One extra bit so that addr < DEPTH is well defined even when DEPTH fills the address space.
    localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

    logic             in_range;
    logic             sel_valid;
    logic             sel_ready;
    logic             accept;
    logic [DEPTH-1:0] wr_en;

    always_comb begin
        in_range  = ({1'b0, addr} < DEPTH_EXT);
        sel_valid = 1'b0;
        sel_ready = 1'b0;
        wr_en     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (addr == ADDR_WIDTH'(i)) begin
                sel_valid = q_valid[i];
                sel_ready = q_ready[i];
            end
        end
        d_ready = in_range ? (~sel_valid | sel_ready) : 1'b1;
        accept  = d_valid & d_ready;
        for (int i = 0; i < DEPTH; i++) begin
            wr_en[i] = accept & in_range & (addr == ADDR_WIDTH'(i));
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_chan
        logic [WIDTH-1:0] buf_data;
        logic             buf_full;

        // A write wins over a drain so a full channel can stream one word per cycle.
        always_ff @(posedge clk or negedge n_rst) begin
            if (!n_rst) begin
                buf_data <= '0;
                buf_full <= 1'b0;
            end else if (wr_en[g]) begin
                buf_data <= d;
                buf_full <= 1'b1;
            end else if (q_ready[g]) begin
                buf_full <= 1'b0;
            end
        end

        assign q[g]       = buf_data;
        assign q_valid[g] = buf_full;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            drop <= 1'b0;
        end else begin
            drop <= accept & ~in_range;
        end
    end

`ifdef DEMUX_DROP_CNT_EN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            drop_cnt <= 8'h00;
        end else if (accept && !in_range && drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 8'h01;
        end
    end
`endif

endmodule

// File: tb/tb_stream_demultiplexer.sv
// Scoreboard bench for stream_demultiplexer (WIDTH=8, DEPTH=3); define
// DEMUX_DROP_CNT_EN to also exercise the drop counter.
module tb_stream_demultiplexer;

    localparam int WIDTH = 8;
    localparam int DEPTH = 3;

    logic             clk = 1'b0;
    logic             n_rst = 1'b0;
    logic [1:0]       addr = '0;
    logic [WIDTH-1:0] d = '0;
    logic             d_valid = 1'b0;
    logic             d_ready;
    logic [WIDTH-1:0] q [DEPTH-1:0];
    logic [DEPTH-1:0] q_valid;
    logic [DEPTH-1:0] q_ready = '0;
    logic             drop;
`ifdef DEMUX_DROP_CNT_EN
    logic [7:0]       drop_cnt;
`endif

    int               check_count = 0;
    int               pass_count = 0;
    logic [WIDTH-1:0] exp_q [DEPTH][$];
    logic             exp_drop = 1'b0;

    always #5 clk = ~clk;

    stream_demultiplexer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .addr     (addr),
        .d        (d),
        .d_valid  (d_valid),
        .d_ready  (d_ready),
        .q        (q),
        .q_valid  (q_valid),
        .q_ready  (q_ready),
`ifdef DEMUX_DROP_CNT_EN
        .drop     (drop),
        .drop_cnt (drop_cnt)
`else
        .drop     (drop)
`endif
    );

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual === expected) pass_count++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    task automatic apply_stimulus(input logic [1:0] a, input logic [7:0] data, input logic v, input logic [2:0] rdy);
        addr    = a;
        d       = data;
        d_valid = v;
        q_ready = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: checks every drained word against the scoreboard and the drop pulse
    // against the previous cycle's out-of-range acceptance, then records new acceptances.
    always @(negedge clk) begin
        if (!n_rst) begin
            exp_drop = 1'b0;
        end else begin
            check_output("drop_pulse", drop, exp_drop);
            for (int i = 0; i < DEPTH; i++) begin
                if (q_valid[i] && q_ready[i]) begin
                    if (exp_q[i].size() == 0) begin
                        check_count++;
                        $display("[TB] FAIL unexpected_drain_q%0d: got 0x%0h, expected no word", i, q[i]);
                    end else begin
                        check_output($sformatf("drain_q%0d", i), q[i], exp_q[i].pop_front());
                    end
                end
            end
            if (d_valid && d_ready && int'(addr) < DEPTH) exp_q[addr].push_back(d);
            exp_drop = d_valid && d_ready && (int'(addr) >= DEPTH);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        apply_stimulus(2'd0, 8'h00, 1'b0, 3'b000);
        #2;
        check_output("reset_q_valid", q_valid, 3'b000);
        check_output("reset_drop", drop, 1'b0);
        for (int i = 0; i < DEPTH; i++) check_output($sformatf("reset_q%0d", i), q[i], 8'h00);
        tick();
        n_rst = 1'b1;

        // Route a single word to channel 2 with no consumer ready
        apply_stimulus(2'd2, 8'hA5, 1'b1, 3'b000);
        tick();
        apply_stimulus(2'd0, 8'h00, 1'b0, 3'b000);
        @(negedge clk);
        check_output("route_q_valid", q_valid, 3'b100);
        check_output("route_q2", q[2], 8'hA5);
        check_output("route_q0", q[0], 8'h00);
        check_output("route_q1", q[1], 8'h00);
        tick();

        // Backpressure on full channel 2, then drain-and-write in the same cycle
        apply_stimulus(2'd2, 8'h5A, 1'b1, 3'b000);
        @(negedge clk);
        check_output("bp_ready_full", d_ready, 1'b0);
        tick();
        @(negedge clk);
        check_output("bp_ready_still_full", d_ready, 1'b0);
        check_output("bp_hold_q2", q[2], 8'hA5);
        tick();
        apply_stimulus(2'd2, 8'h5A, 1'b1, 3'b100);
        @(negedge clk);
        check_output("drain_write_ready", d_ready, 1'b1);
        tick();
        apply_stimulus(2'd0, 8'h11, 1'b1, 3'b000);
        @(negedge clk);
        check_output("other_ch_ready", d_ready, 1'b1);
        tick();
        apply_stimulus(2'd0, 8'h00, 1'b0, 3'b000);
        @(negedge clk);
        check_output("other_ch_q_valid", q_valid, 3'b101);
        check_output("other_ch_q0", q[0], 8'h11);
        check_output("other_ch_q2", q[2], 8'h5A);
        tick();

        // Single drain of channel 2: valid clears, data holds
        apply_stimulus(2'd0, 8'h00, 1'b0, 3'b100);
        tick();
        apply_stimulus(2'd0, 8'h00, 1'b0, 3'b000);
        @(negedge clk);
        check_output("drain_q_valid", q_valid, 3'b001);
        check_output("drain_hold_q2", q[2], 8'h5A);
        tick();

        // Back-to-back streaming through channel 1
        for (int v = 1; v <= 4; v++) begin
            apply_stimulus(2'd1, 8'(v), 1'b1, 3'b010);
            @(negedge clk);
            check_output($sformatf("stream_ready_%0d", v), d_ready, 1'b1);
            tick();
        end
        apply_stimulus(2'd1, 8'h00, 1'b0, 3'b010);
        @(negedge clk);
        check_output("stream_last_valid", q_valid[1], 1'b1);
        check_output("stream_last_q1", q[1], 8'h04);
        tick();
        apply_stimulus(2'd0, 8'h00, 1'b0, 3'b000);
        @(negedge clk);
        check_output("stream_done_q_valid", q_valid, 3'b001);
        check_output("stream_done_hold_q1", q[1], 8'h04);
        tick();

        // Out-of-range word is consumed and dropped
        apply_stimulus(2'd3, 8'hFF, 1'b1, 3'b000);
        @(negedge clk);
        check_output("oor_ready", d_ready, 1'b1);
        tick();
        apply_stimulus(2'd0, 8'h00, 1'b0, 3'b000);
        @(negedge clk);
        check_output("oor_drop", drop, 1'b1);
        check_output("oor_q_valid", q_valid, 3'b001);
        check_output("oor_q0", q[0], 8'h11);
`ifdef DEMUX_DROP_CNT_EN
        check_output("oor_drop_cnt", drop_cnt, 8'h01);
`endif
        tick();
        @(negedge clk);
        check_output("oor_drop_pulse_end", drop, 1'b0);
        tick();

        // Asynchronous reset in the middle of traffic
        apply_stimulus(2'd1, 8'h77, 1'b1, 3'b000);
        tick();
        apply_stimulus(2'd3, 8'h33, 1'b1, 3'b000);
        tick();
        apply_stimulus(2'd0, 8'h00, 1'b0, 3'b000);
        #1;
        check_output("pre_reset_q_valid", q_valid, 3'b011);
        check_output("pre_reset_drop", drop, 1'b1);
        #1;
        n_rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) exp_q[i].delete();
        #1;
        check_output("midrun_reset_q_valid", q_valid, 3'b000);
        check_output("midrun_reset_drop", drop, 1'b0);
        for (int i = 0; i < DEPTH; i++) check_output($sformatf("midrun_reset_q%0d", i), q[i], 8'h00);
        tick();
        n_rst = 1'b1;

`ifdef DEMUX_DROP_CNT_EN
        check_output("drop_cnt_reset", drop_cnt, 8'h00);
        apply_stimulus(2'd3, 8'hC3, 1'b1, 3'b000);
        repeat (300) tick();
        apply_stimulus(2'd0, 8'h00, 1'b0, 3'b000);
        @(negedge clk);
        check_output("drop_cnt_saturate", drop_cnt, 8'hFF);
        tick();
`endif

        // Fill two channels, then drain everything at once
        apply_stimulus(2'd0, 8'h42, 1'b1, 3'b000);
        tick();
        apply_stimulus(2'd2, 8'h24, 1'b1, 3'b000);
        tick();
        apply_stimulus(2'd0, 8'h00, 1'b0, 3'b111);
        tick();
        apply_stimulus(2'd0, 8'h00, 1'b0, 3'b000);
        @(negedge clk);
        check_output("final_q_valid", q_valid, 3'b000);
        for (int i = 0; i < DEPTH; i++) check_output($sformatf("scoreboard_empty_q%0d", i), exp_q[i].size(), 0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
